lcd_hd44780_ctrl: RTL and testbench

Parametrised HD44780-style character-LCD controller: second-generation panel driver. It adds a selectable 4-bit/8-bit bus mode, a command FIFO with a valid/ready handshake, and clock-rate-independent timing. It sits between the host command logic and the LCD pins. After reset it runs power-up and initialisation on its own, then replays queued {rs, rw, data} transfers with HD44780 enable-pulse timing.

---
 rtl/lcd_hd44780_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_hd44780_ctrl
// Purpose  : HD44780-style character-LCD controller. Runs power-up delay and
//            the panel init sequence on its own, then replays queued
//            {rs, rw, data} words from a command FIFO with enable-pulse timing.
//            Supports an 8-bit bus or a 4-bit nibble bus on lcd_data[7:4].
// Ports    : clk, rst_n (async, active-low)
//            cfg[6:0]      {N, F, D, C, B, I/D, S}, sampled at end of power-up
//            cmd_valid / cmd_data[9:0] / cmd_ready   host push handshake
//            e, rs, rw, lcd_data[7:0]                LCD pins
//            busy, init_done, fifo_count             status
// Revision : 1.0  initial release
// ============================================================================
module lcd_hd44780_ctrl #(
    parameter int CLK_PER_US    = 3,
    parameter int BUS_MODE      = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int POWERUP_US    = 500,
    parameter int CMD_WAIT_US   = 50,
    parameter int CLEAR_WAIT_US = 200
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [6:0]                    cfg,
    input  logic                          cmd_valid,
    input  logic [9:0]                    cmd_data,
    output logic                          cmd_ready,
    output logic                          e,
    output logic                          rs,
    output logic                          rw,
    output logic [7:0]                    lcd_data,
    output logic                          busy,
    output logic                          init_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int POWERUP_CYC = POWERUP_US * CLK_PER_US;
    localparam int WIN_CYC     = 27 * CLK_PER_US;
    localparam int E_ON        = CLK_PER_US;
    localparam int E_OFF       = 14 * CLK_PER_US;
    localparam int CMD_HOLD    = CMD_WAIT_US * CLK_PER_US;
    localparam int CLR_HOLD    = CLEAR_WAIT_US * CLK_PER_US;
    localparam int ENTRY_HOLD  = 2 * CMD_HOLD;
    localparam int MAX_A       = (POWERUP_CYC > CLR_HOLD) ? POWERUP_CYC : CLR_HOLD;
    localparam int MAX_B       = (ENTRY_HOLD > WIN_CYC) ? ENTRY_HOLD : WIN_CYC;
    localparam int TMR_MAX     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W       = $clog2(TMR_MAX + 1);
    localparam bit NIBBLE      = (BUS_MODE == 4);
    // Init step 0 is the 4-bit-only preamble nibble; 8-bit mode starts at 1.
    localparam logic [2:0] FIRST_STEP = NIBBLE ? 3'd0 : 3'd1;
    localparam logic [2:0] LAST_STEP  = 3'd4;

    typedef enum logic [1:0] {
        S_POWERUP = 2'd0,
        S_INIT    = 2'd1,
        S_IDLE    = 2'd2,
        S_XFER    = 2'd3
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  tmr;
    logic [TMR_W-1:0]  hold_end;
    logic              in_hold;
    logic              last_win;
    logic [3:0]        low_nib;
    logic [2:0]        init_step;
    logic [6:0]        cfg_r;

    logic [9:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_nxt;
    logic              push;
    logic              pop;
    logic [9:0]        head;

    logic [6:0]        cfg_sel;
    logic [2:0]        sel_step;
    logic [9:0]        ld_word;
    logic              ld_single;
    logic [TMR_W-1:0]  ld_hold_end;
    logic              start;
    logic              is_clear_home;

    assign push = cmd_valid && cmd_ready;
    // fifo_count is registered, so a word pushed into an empty FIFO is only
    // visible (and popped) on the following cycle.
    assign pop  = (state == S_IDLE) && (fifo_count != '0);
    assign head = mem[rd_ptr];

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop) begin
            count_nxt = fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cmd_ready  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_nxt;
            cmd_ready  <= (count_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    // ------------------------------------------------------------------
    // Selection of the next transfer. A new transfer starts on the same edge
    // the previous phase ends, so back-to-back init steps have no gap.
    // cfg is used directly on the power-up edge because cfg_r is only being
    // loaded on that edge.
    // ------------------------------------------------------------------
    always_comb begin
        start = 1'b0;
        case (state)
            S_POWERUP: start = (tmr == TMR_W'(POWERUP_CYC));
            S_INIT:    start = in_hold && (tmr == hold_end) && (init_step != LAST_STEP);
            S_IDLE:    start = pop;
            default:   start = 1'b0;
        endcase
    end

    always_comb begin
        cfg_sel       = (state == S_POWERUP) ? cfg : cfg_r;
        sel_step      = (state == S_POWERUP) ? FIRST_STEP : (init_step + 3'd1);
        is_clear_home = !head[9] && (head[7:2] == 6'd0) && (head[1:0] != 2'd0);
        ld_word       = 10'h001;
        ld_single     = NIBBLE ? 1'b0 : 1'b1;
        ld_hold_end   = TMR_W'(CMD_HOLD - 1);
        if (state == S_IDLE) begin
            ld_word = head;
            if (is_clear_home) begin
                ld_hold_end = TMR_W'(CLR_HOLD - 1);
            end
        end else begin
            case (sel_step)
                3'd0: begin
                    ld_word   = {2'b00, 8'h20};
                    ld_single = 1'b1;
                end
                3'd1: ld_word = {2'b00, 3'b001, (NIBBLE ? 1'b0 : 1'b1), cfg_sel[6], cfg_sel[5], 2'b00};
                3'd2: ld_word = {2'b00, 5'b00001, cfg_sel[4:2]};
                3'd3: begin
                    ld_word     = {2'b00, 8'h01};
                    ld_hold_end = TMR_W'(CLR_HOLD - 1);
                end
                default: begin
                    ld_word     = {2'b00, 6'b000001, cfg_sel[1:0]};
                    ld_hold_end = TMR_W'(ENTRY_HOLD - 1);
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Main FSM and transfer engine (registered pin outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_POWERUP;
            tmr       <= '0;
            hold_end  <= '0;
            in_hold   <= 1'b0;
            last_win  <= 1'b0;
            low_nib   <= 4'h0;
            init_step <= 3'd0;
            cfg_r     <= 7'd0;
            e         <= 1'b0;
            rs        <= 1'b0;
            rw        <= 1'b0;
            lcd_data  <= 8'h00;
            busy      <= 1'b1;
            init_done <= 1'b0;
        end else begin
            case (state)
                S_POWERUP: begin
                    if (tmr != TMR_W'(POWERUP_CYC)) begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                S_INIT, S_XFER: begin
                    if (!in_hold) begin
                        if (tmr == TMR_W'(WIN_CYC - 1)) begin
                            tmr <= '0;
                            e   <= 1'b0;
                            if (last_win) begin
                                in_hold  <= 1'b1;
                                rs       <= 1'b0;
                                rw       <= 1'b0;
                                lcd_data <= 8'h00;
                            end else begin
                                // second nibble window, rs/rw unchanged
                                last_win <= 1'b1;
                                lcd_data <= {low_nib, 4'h0};
                            end
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                            // e reflects the window cycle being entered (tmr+1)
                            e   <= (tmr >= TMR_W'(E_ON - 1)) && (tmr < TMR_W'(E_OFF - 1));
                        end
                    end else if (tmr == hold_end) begin
                        if (state == S_XFER) begin
                            state <= S_IDLE;
                        end else if (init_step == LAST_STEP) begin
                            state     <= S_IDLE;
                            init_done <= 1'b1;
                        end
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: ;
            endcase

            if (start) begin
                if (state == S_IDLE) begin
                    state <= S_XFER;
                end else begin
                    state     <= S_INIT;
                    init_step <= sel_step;
                end
                if (state == S_POWERUP) begin
                    cfg_r <= cfg;
                end
                tmr      <= '0;
                in_hold  <= 1'b0;
                last_win <= ld_single;
                hold_end <= ld_hold_end;
                low_nib  <= ld_word[3:0];
                e        <= 1'b0;
                rs       <= ld_word[9];
                rw       <= ld_word[8];
                lcd_data <= NIBBLE ? {ld_word[7:4], 4'h0} : ld_word[7:0];
            end

            busy <= !((state == S_IDLE) && (fifo_count == '0) && init_done);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_hd44780_ctrl
// Purpose  : Directed self-checking bench for lcd_hd44780_ctrl. One instance
//            in 8-bit mode carries all host traffic; a second instance in
//            4-bit mode checks the nibble init sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd_hd44780_ctrl;

    logic       clk = 1'b0;
    logic       rst8_n, rst4_n;
    logic [6:0] cfg;
    logic       v8, v4;
    logic [9:0] d8, d4;

    logic       rdy8, e8, rs8, rw8, busy8, idone8;
    logic [7:0] ld8;
    logic [2:0] cnt8;
    logic       rdy4, e4, rs4, rw4, busy4, idone4;
    logic [7:0] ld4;
    logic [2:0] cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lcd_hd44780_ctrl #(.CLK_PER_US(3), .BUS_MODE(8), .FIFO_DEPTH(4)) dut8 (
        .clk(clk), .rst_n(rst8_n), .cfg(cfg), .cmd_valid(v8), .cmd_data(d8),
        .cmd_ready(rdy8), .e(e8), .rs(rs8), .rw(rw8), .lcd_data(ld8),
        .busy(busy8), .init_done(idone8), .fifo_count(cnt8)
    );

    lcd_hd44780_ctrl #(.CLK_PER_US(3), .BUS_MODE(4), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .cfg(cfg), .cmd_valid(v4), .cmd_data(d4),
        .cmd_ready(rdy4), .e(e4), .rs(rs4), .rw(rw4), .lcd_data(ld4),
        .busy(busy4), .init_done(idone4), .fifo_count(cnt4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst8_n = 1'b0; rst4_n = 1'b0;
        v8 = 1'b0; d8 = '0; v4 = 1'b0; d4 = '0;
        // N=1 F=0 D=1 C=0 B=0 I/D=1 S=0 -> 0x38 / 0x0C / 0x06
        cfg = 7'b1010010;
        repeat (3) step();
        checks++; if (e8 !== 1'b0) begin failures++; $display("FAIL reset_e got=%b exp=0", e8); end
        checks++; if (rs8 !== 1'b0) begin failures++; $display("FAIL reset_rs got=%b exp=0", rs8); end
        checks++; if (rw8 !== 1'b0) begin failures++; $display("FAIL reset_rw got=%b exp=0", rw8); end
        checks++; if (ld8 !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", ld8); end
        checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy8); end
        checks++; if (idone8 !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", idone8); end
        checks++; if (rdy8 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", rdy8); end
        checks++; if (cnt8 !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt8); end
        checks++; if (e4 !== 1'b0 || ld4 !== 8'h00) begin failures++; $display("FAIL reset4_pins got=%b/%h exp=0/00", e4, ld4); end
    endtask

    task automatic test_init_4bit();
        logic [7:0] exp4 [9];
        logic [7:0] got  [9];
        int  nr = 0, done_c = -1, first = -1;
        bit  pe = 1'b0, low_bad = 1'b0;
        exp4 = '{8'h20, 8'h20, 8'h80, 8'h00, 8'hC0, 8'h00, 8'h10, 8'h00, 8'h60};
        @(negedge clk); rst4_n = 1'b1;
        for (int c = 0; c < 3700; c++) begin
            step();
            if (e4 && !pe) begin
                if (nr < 9) got[nr] = ld4;
                if (nr == 0) first = c;
                nr++;
            end
            pe = e4;
            if (ld4[3:0] !== 4'h0) low_bad = 1'b1;
            if (idone4 && done_c < 0) done_c = c;
        end
        checks++; if (first < 1500) begin failures++; $display("FAIL init4_first_pulse got=%0d exp>=1500", first); end
        checks++; if (nr != 9) begin failures++; $display("FAIL init4_pulses got=%0d exp=9", nr); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i < nr && got[i] !== exp4[i]) begin failures++; $display("FAIL init4_nibble%0d got=%h exp=%h", i, got[i], exp4[i]); end
        end
        checks++; if (low_bad) begin failures++; $display("FAIL init4_low_nibble got=nonzero exp=0"); end
        checks++; if (done_c != 3579) begin failures++; $display("FAIL init4_done_cycle got=%0d exp=3579", done_c); end
    endtask

    task automatic test_init_8bit();
        logic [7:0] exp8 [4];
        logic [7:0] got  [4];
        int  nr = 0, done_c = -1, first = -1;
        bit  pe = 1'b0;
        exp8 = '{8'h38, 8'h0C, 8'h01, 8'h06};
        @(negedge clk); rst8_n = 1'b1;
        for (int c = 0; c < 3100; c++) begin
            step();
            if (e8 && !pe) begin
                if (nr < 4) got[nr] = ld8;
                if (nr == 0) first = c;
                nr++;
            end
            pe = e8;
            if (idone8 && done_c < 0) done_c = c;
        end
        checks++; if (first < 1500) begin failures++; $display("FAIL init8_first_pulse got=%0d exp>=1500", first); end
        checks++; if (nr != 4) begin failures++; $display("FAIL init8_pulses got=%0d exp=4", nr); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i < nr && got[i] !== exp8[i]) begin failures++; $display("FAIL init8_byte%0d got=%h exp=%h", i, got[i], exp8[i]); end
        end
        checks++; if (done_c != 3024) begin failures++; $display("FAIL init8_done_cycle got=%0d exp=3024", done_c); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL init8_idle_busy got=%b exp=0", busy8); end
    endtask

    task automatic test_single_write();
        int n_data = 0, n_e = 0, fall = -1, first_e = -1;
        @(negedge clk);
        checks++; if (busy8 !== 1'b0 || rdy8 !== 1'b1) begin failures++; $display("FAIL write_pre_idle got=%b/%b exp=0/1", busy8, rdy8); end
        v8 = 1'b1; d8 = {1'b1, 1'b0, 8'h41};
        step();
        v8 = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (rs8 && !rw8 && ld8 == 8'h41) n_data++;
            if (e8) begin
                n_e++;
                if (first_e < 0) first_e = k;
            end
            if (k == 1) begin
                checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL write_busy_rise got=%b exp=1", busy8); end
            end
            if (!busy8 && fall < 0) fall = k;
        end
        checks++; if (n_data != 81) begin failures++; $display("FAIL write_window got=%0d exp=81", n_data); end
        checks++; if (n_e != 39) begin failures++; $display("FAIL write_e_width got=%0d exp=39", n_e); end
        checks++; if (first_e != 4) begin failures++; $display("FAIL write_e_start got=%0d exp=4", first_e); end
        checks++; if (fall != 233) begin failures++; $display("FAIL write_busy_fall got=%0d exp=233", fall); end
        checks++; if (ld8 !== 8'h00 || rs8 !== 1'b0) begin failures++; $display("FAIL write_hold_bus got=%h/%b exp=00/0", ld8, rs8); end
    endtask

    task automatic test_back_to_back();
        int  rc [3];
        logic [8:0] rd [3];
        int  nr = 0;
        bit  pe = 1'b0;
        @(negedge clk);
        v8 = 1'b1; d8 = {2'b00, 8'h01};
        step();
        checks++; if (cnt8 !== 3'd1) begin failures++; $display("FAIL b2b_count1 got=%0d exp=1", cnt8); end
        d8 = {2'b00, 8'h80};
        step();
        checks++; if (cnt8 !== 3'd1) begin failures++; $display("FAIL b2b_push_pop_count got=%0d exp=1", cnt8); end
        d8 = {2'b00, 8'h80};
        step();
        v8 = 1'b0;
        checks++; if (cnt8 !== 3'd2) begin failures++; $display("FAIL b2b_count2 got=%0d exp=2", cnt8); end
        for (int k = 1; k <= 1300; k++) begin
            step();
            if (e8 && !pe) begin
                if (nr < 3) begin rc[nr] = k; rd[nr] = {rs8, ld8}; end
                nr++;
            end
            pe = e8;
        end
        checks++; if (nr != 3) begin failures++; $display("FAIL b2b_pulses got=%0d exp=3", nr); end
        if (nr == 3) begin
            checks++; if (rc[1] - rc[0] != 682) begin failures++; $display("FAIL b2b_clear_gap got=%0d exp=682", rc[1] - rc[0]); end
            checks++; if (rc[2] - rc[1] != 232) begin failures++; $display("FAIL b2b_cmd_gap got=%0d exp=232", rc[2] - rc[1]); end
            checks++; if (rd[0] !== 9'h001) begin failures++; $display("FAIL b2b_word0 got=%h exp=001", rd[0]); end
            checks++; if (rd[1] !== 9'h080 || rd[2] !== 9'h080) begin failures++; $display("FAIL b2b_word12 got=%h/%h exp=080/080", rd[1], rd[2]); end
        end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL b2b_end_busy got=%b exp=0", busy8); end
    endtask

    task automatic test_fifo_full();
        logic [9:0] w5 [5];
        logic [9:0] gd [5];
        int  nr = 0, acc = -1, done_c = -1, first = -1;
        bit  pe = 1'b0, prev_rdy;
        w5 = '{{2'b10, 8'h48}, {2'b10, 8'h45}, {2'b11, 8'h4C}, {2'b10, 8'h4C}, {2'b10, 8'h4F}};
        @(negedge clk); rst8_n = 1'b0;
        @(negedge clk); rst8_n = 1'b1;
        v8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d8 = w5[i];
            step();
        end
        d8 = w5[4];
        checks++; if (rdy8 !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", rdy8); end
        checks++; if (cnt8 !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", cnt8); end
        prev_rdy = rdy8;
        for (int c = 4; c < 4300; c++) begin
            step();
            if (v8 && prev_rdy) begin v8 = 1'b0; acc = c; end
            prev_rdy = rdy8;
            if (e8 && !pe && rs8) begin
                if (nr < 5) gd[nr] = {rs8, rw8, ld8};
                if (nr == 0) first = c;
                nr++;
            end
            pe = e8;
            if (idone8 && done_c < 0) done_c = c;
        end
        checks++; if (done_c != 3024) begin failures++; $display("FAIL full_done_cycle got=%0d exp=3024", done_c); end
        checks++; if (acc != 3026) begin failures++; $display("FAIL full_fifth_accept got=%0d exp=3026", acc); end
        checks++; if (first != 3028) begin failures++; $display("FAIL full_first_word got=%0d exp=3028", first); end
        checks++; if (nr != 5) begin failures++; $display("FAIL full_words got=%0d exp=5", nr); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i < nr && gd[i] !== w5[i]) begin failures++; $display("FAIL full_order%0d got=%h exp=%h", i, gd[i], w5[i]); end
        end
        checks++; if (cnt8 !== 3'd0 || busy8 !== 1'b0) begin failures++; $display("FAIL full_drain got=%0d/%b exp=0/0", cnt8, busy8); end
    endtask

    task automatic test_reset_mid_xfer();
        int  first = -1;
        logic [8:0] fw = '0;
        bit  pe = 1'b0;
        @(negedge clk);
        v8 = 1'b1; d8 = {2'b10, 8'h51};
        step();
        d8 = {2'b10, 8'h52};
        step();
        d8 = {2'b10, 8'h53};
        step();
        v8 = 1'b0;
        checks++; if (cnt8 !== 3'd2) begin failures++; $display("FAIL midrst_queued got=%0d exp=2", cnt8); end
        for (int k = 0; k < 40; k++) begin
            if (e8) break;
            step();
        end
        checks++; if (e8 !== 1'b1) begin failures++; $display("FAIL midrst_e_wait got=%b exp=1", e8); end
        #2 rst8_n = 1'b0;
        #1;
        checks++; if (e8 !== 1'b0) begin failures++; $display("FAIL midrst_e got=%b exp=0", e8); end
        checks++; if (rs8 !== 1'b0 || rw8 !== 1'b0) begin failures++; $display("FAIL midrst_rs_rw got=%b/%b exp=0/0", rs8, rw8); end
        checks++; if (ld8 !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", ld8); end
        checks++; if (busy8 !== 1'b1 || idone8 !== 1'b0) begin failures++; $display("FAIL midrst_status got=%b/%b exp=1/0", busy8, idone8); end
        checks++; if (cnt8 !== 3'd0 || rdy8 !== 1'b1) begin failures++; $display("FAIL midrst_fifo got=%0d/%b exp=0/1", cnt8, rdy8); end
        @(negedge clk); rst8_n = 1'b1;
        for (int c = 0; c < 1600; c++) begin
            step();
            if (e8 && !pe && first < 0) begin first = c; fw = {rs8, ld8}; end
            pe = e8;
        end
        checks++; if (first < 1500 || first >= 1581) begin failures++; $display("FAIL midrst_repowerup got=%0d exp=1500..1580", first); end
        checks++; if (fw !== 9'h038) begin failures++; $display("FAIL midrst_fresh_init got=%h exp=038", fw); end
    endtask

    initial begin
        test_reset();
        test_init_4bit();
        test_init_8bit();
        test_single_write();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_xfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
